bit_truncator: RTL and testbench



---
 rtl/bit_truncator.sv | 103 ++++++++++
 tb/tb_bit_truncator.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/bit_truncator.sv
// Narrows DATA_WIDTH words to IMMDATA_WIDTH through a 2-entry elastic buffer,
// flagging (and optionally clamping) words whose discarded upper bits are set.
module bit_truncator #(
    parameter int DATA_WIDTH    = 32,
    parameter int IMMDATA_WIDTH = 21,
    parameter int SATURATE      = 0,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [DATA_WIDTH-1:0]    IDATA,
    input  logic                     IVALID,
    output logic                     IREADY,
    output logic [IMMDATA_WIDTH-1:0] ODATA,
    output logic                     OOVF,
    output logic                     OVALID,
    input  logic                     OREADY,
    input  logic                     CLRCNT,
    output logic [CNT_WIDTH-1:0]     OVFCNT
);

    if (IMMDATA_WIDTH >= DATA_WIDTH) begin : g_width_check
        $error("bit_truncator: IMMDATA_WIDTH must be smaller than DATA_WIDTH");
    end

    // Handshake: a word moves when valid and ready are both high at a rising
    // edge. IREADY and OVALID depend on registered state only, so there is
    // no combinational path from OREADY to IREADY or from IDATA to ODATA.
    logic [IMMDATA_WIDTH-1:0] mem_data [2];
    logic [1:0]               mem_ovf;
    logic                     wr_ptr;
    logic                     rd_ptr;
    logic [1:0]               count;
    logic [CNT_WIDTH-1:0]     ovf_cnt;

    logic                     push;
    logic                     pop;
    logic                     in_ovf;
    logic [IMMDATA_WIDTH-1:0] in_data;

    assign IREADY = (count != 2'd2);
    assign OVALID = (count != 2'd0);
    assign push   = IVALID & IREADY;
    assign pop    = OVALID & OREADY;

    assign in_ovf = |IDATA[DATA_WIDTH-1:IMMDATA_WIDTH];

    always_comb begin
        in_data = IDATA[IMMDATA_WIDTH-1:0];
        if ((SATURATE != 0) && in_ovf) begin
            in_data = '1;
        end
    end

    // Head entry is gated so an empty buffer always presents zeros.
    always_comb begin
        ODATA = '0;
        OOVF  = 1'b0;
        if (OVALID) begin
            ODATA = mem_data[rd_ptr];
            OOVF  = mem_ovf[rd_ptr];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            mem_data[0] <= '0;
            mem_data[1] <= '0;
            mem_ovf     <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= in_data;
                mem_ovf[wr_ptr]  <= in_ovf;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Counts accepted overflowing words; clear wins over a same-cycle increment.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ovf_cnt <= '0;
        end else if (CLRCNT) begin
            ovf_cnt <= '0;
        end else if (push && in_ovf && (ovf_cnt != {CNT_WIDTH{1'b1}})) begin
            ovf_cnt <= ovf_cnt + 1'b1;
        end
    end

    assign OVFCNT = ovf_cnt;

endmodule

// File: tb/tb_bit_truncator.sv
// Directed bench for bit_truncator: a wrapping and a saturating instance
// share one stimulus stream; each scenario task checks its own results.
module tb_bit_truncator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] idata;
    logic        ivalid;
    logic        oready;
    logic        clrcnt;

    logic        iready0, oovf0, ovalid0;
    logic [20:0] odata0;
    logic [7:0]  ovfcnt0;
    logic        iready1, oovf1, ovalid1;
    logic [20:0] odata1;
    logic [7:0]  ovfcnt1;

    int errors = 0;
    int checks = 0;

    logic [21:0] exp_q [$];

    always #5 clk = ~clk;

    bit_truncator #(.DATA_WIDTH(32), .IMMDATA_WIDTH(21), .SATURATE(0), .CNT_WIDTH(8)) u_wrap (
        .CLK(clk), .RST_N(rst_n), .IDATA(idata), .IVALID(ivalid), .IREADY(iready0),
        .ODATA(odata0), .OOVF(oovf0), .OVALID(ovalid0), .OREADY(oready),
        .CLRCNT(clrcnt), .OVFCNT(ovfcnt0)
    );

    bit_truncator #(.DATA_WIDTH(32), .IMMDATA_WIDTH(21), .SATURATE(1), .CNT_WIDTH(8)) u_sat (
        .CLK(clk), .RST_N(rst_n), .IDATA(idata), .IVALID(ivalid), .IREADY(iready1),
        .ODATA(odata1), .OOVF(oovf1), .OVALID(ovalid1), .OREADY(oready),
        .CLRCNT(clrcnt), .OVFCNT(ovfcnt1)
    );

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ivalid = 1'b0; oready = 1'b0; clrcnt = 1'b0; idata = '0;
        tick();
        tick();
        checks++; if (ovalid0 !== 1'b0) begin errors++; $display("FAIL reset_ovalid got=%b exp=0", ovalid0); end
        checks++; if (odata0 !== 21'h0) begin errors++; $display("FAIL reset_odata got=%h exp=0", odata0); end
        checks++; if (oovf0 !== 1'b0) begin errors++; $display("FAIL reset_oovf got=%b exp=0", oovf0); end
        checks++; if (ovfcnt0 !== 8'd0) begin errors++; $display("FAIL reset_ovfcnt got=%0d exp=0", ovfcnt0); end
        checks++; if (iready0 !== 1'b1) begin errors++; $display("FAIL reset_iready got=%b exp=1", iready0); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        idata = 32'h000ABCDE; ivalid = 1'b1; oready = 1'b1;
        tick();
        ivalid = 1'b0;
        checks++; if (ovalid0 !== 1'b1) begin errors++; $display("FAIL basic_ovalid got=%b exp=1", ovalid0); end
        checks++; if (odata0 !== 21'h0ABCDE) begin errors++; $display("FAIL basic_odata got=%h exp=0abcde", odata0); end
        checks++; if (oovf0 !== 1'b0) begin errors++; $display("FAIL basic_oovf got=%b exp=0", oovf0); end
        checks++; if (ovfcnt0 !== 8'd0) begin errors++; $display("FAIL basic_ovfcnt got=%0d exp=0", ovfcnt0); end
        tick();
        checks++; if (ovalid0 !== 1'b0) begin errors++; $display("FAIL basic_drain_ovalid got=%b exp=0", ovalid0); end
        checks++; if (odata0 !== 21'h0) begin errors++; $display("FAIL basic_drain_odata got=%h exp=0", odata0); end
    endtask

    task automatic test_overflow();
        oready = 1'b1;
        idata = 32'h80123456; ivalid = 1'b1;
        tick();
        checks++; if (odata0 !== 21'h123456) begin errors++; $display("FAIL ovf_wrap_odata got=%h exp=123456", odata0); end
        checks++; if (oovf0 !== 1'b1) begin errors++; $display("FAIL ovf_wrap_oovf got=%b exp=1", oovf0); end
        checks++; if (ovfcnt0 !== 8'd1) begin errors++; $display("FAIL ovf_wrap_cnt got=%0d exp=1", ovfcnt0); end
        checks++; if (odata1 !== 21'h1FFFFF) begin errors++; $display("FAIL ovf_sat_odata got=%h exp=1fffff", odata1); end
        checks++; if (oovf1 !== 1'b1) begin errors++; $display("FAIL ovf_sat_oovf got=%b exp=1", oovf1); end
        // Lowest discarded bit alone must still be flagged.
        idata = 32'h00200000;
        tick();
        checks++; if (odata0 !== 21'h0 || oovf0 !== 1'b1) begin errors++; $display("FAIL ovf_bit21_wrap got=%h/%b exp=0/1", odata0, oovf0); end
        checks++; if (odata1 !== 21'h1FFFFF || oovf1 !== 1'b1) begin errors++; $display("FAIL ovf_bit21_sat got=%h/%b exp=1fffff/1", odata1, oovf1); end
        idata = 32'h001FFFFF;
        tick();
        checks++; if (odata0 !== 21'h1FFFFF || oovf0 !== 1'b0) begin errors++; $display("FAIL ovf_max_fit got=%h/%b exp=1fffff/0", odata0, oovf0); end
        checks++; if (ovfcnt0 !== 8'd2) begin errors++; $display("FAIL ovf_cnt2 got=%0d exp=2", ovfcnt0); end
        ivalid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        oready = 1'b0; ivalid = 1'b1; idata = 32'h1;
        tick();
        checks++; if (iready0 !== 1'b1) begin errors++; $display("FAIL bp_iready_one got=%b exp=1", iready0); end
        idata = 32'h2;
        tick();
        checks++; if (iready0 !== 1'b0) begin errors++; $display("FAIL bp_iready_full got=%b exp=0", iready0); end
        checks++; if (ovalid0 !== 1'b1 || odata0 !== 21'h1) begin errors++; $display("FAIL bp_head got=%b/%h exp=1/000001", ovalid0, odata0); end
        idata = 32'h3;
        tick();
        checks++; if (iready0 !== 1'b0 || odata0 !== 21'h1) begin errors++; $display("FAIL bp_stall got=%b/%h exp=0/000001", iready0, odata0); end
        oready = 1'b1;
        tick();
        checks++; if (odata0 !== 21'h2 || iready0 !== 1'b1) begin errors++; $display("FAIL bp_second got=%h/%b exp=000002/1", odata0, iready0); end
        tick();
        ivalid = 1'b0;
        checks++; if (ovalid0 !== 1'b1 || odata0 !== 21'h3) begin errors++; $display("FAIL bp_third got=%b/%h exp=1/000003", ovalid0, odata0); end
        tick();
        checks++; if (ovalid0 !== 1'b0) begin errors++; $display("FAIL bp_empty got=%b exp=0", ovalid0); end
    endtask

    task automatic test_stream();
        int          exp_cnt;
        logic [31:0] w;
        logic [21:0] e;
        clrcnt = 1'b1;
        tick();
        clrcnt = 1'b0;
        checks++; if (ovfcnt0 !== 8'd0) begin errors++; $display("FAIL stream_clr got=%0d exp=0", ovfcnt0); end
        exp_cnt = 0;
        oready  = 1'b1;
        ivalid  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            w = $urandom;
            if (i % 2 == 1) w = w & 32'h001FFFFF;
            idata = w;
            exp_q.push_back({(w[31:21] != 11'd0), w[20:0]});
            if (w[31:21] != 11'd0) exp_cnt++;
            tick();
            e = exp_q.pop_front();
            checks++;
            if (ovalid0 !== 1'b1 || {oovf0, odata0} !== e) begin
                errors++;
                $display("FAIL stream_word%0d got=%b/%b/%h exp=1/%b/%h", i, ovalid0, oovf0, odata0, e[21], e[20:0]);
            end
        end
        ivalid = 1'b0;
        tick();
        checks++; if (ovalid0 !== 1'b0) begin errors++; $display("FAIL stream_drain got=%b exp=0", ovalid0); end
        checks++; if (ovfcnt0 !== exp_cnt[7:0]) begin errors++; $display("FAIL stream_ovfcnt got=%0d exp=%0d", ovfcnt0, exp_cnt); end
    endtask

    task automatic test_cnt_saturate();
        clrcnt = 1'b1;
        tick();
        clrcnt = 1'b0;
        oready = 1'b1; ivalid = 1'b1; idata = 32'hFFE00000;
        for (int i = 0; i < 254; i++) tick();
        checks++; if (ovfcnt0 !== 8'd254) begin errors++; $display("FAIL cnt_254 got=%0d exp=254", ovfcnt0); end
        for (int i = 0; i < 46; i++) tick();
        checks++; if (ovfcnt0 !== 8'd255) begin errors++; $display("FAIL cnt_sat got=%0d exp=255", ovfcnt0); end
        clrcnt = 1'b1;
        tick();
        clrcnt = 1'b0;
        checks++; if (ovfcnt0 !== 8'd0) begin errors++; $display("FAIL cnt_clr_wins got=%0d exp=0", ovfcnt0); end
        tick();
        checks++; if (ovfcnt0 !== 8'd1) begin errors++; $display("FAIL cnt_after_clr got=%0d exp=1", ovfcnt0); end
        ivalid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        oready = 1'b0; ivalid = 1'b1; idata = 32'h80000011;
        tick();
        idata = 32'h00000022;
        tick();
        ivalid = 1'b0;
        checks++; if (iready0 !== 1'b0 || ovalid0 !== 1'b1) begin errors++; $display("FAIL mid_full got=%b/%b exp=0/1", iready0, ovalid0); end
        rst_n = 1'b0; oready = 1'b1;
        tick();
        rst_n = 1'b1;
        checks++; if (ovalid0 !== 1'b0 || odata0 !== 21'h0) begin errors++; $display("FAIL mid_out got=%b/%h exp=0/0", ovalid0, odata0); end
        checks++; if (ovfcnt0 !== 8'd0 || iready0 !== 1'b1) begin errors++; $display("FAIL mid_state got=%0d/%b exp=0/1", ovfcnt0, iready0); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (ovalid0 !== 1'b0) begin errors++; $display("FAIL mid_ghost%0d got=%b exp=0", i, ovalid0); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_stream();
        test_cnt_saturate();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
